mac_tile_sched: RTL
===================

Name: mac_tile_sched

Overview:
- Job-level scheduler in front of the macarray top.
- Accepts one job per valid/ready handshake: a 12-bit MNT configuration plus a tile grid of (MT+1) x (NT+1) output tiles.
- Issues one single-cycle START per tile, waits for the tile-done indication from the output stage, and inserts a programmable drain gap between tiles.
- Reports job completion and a per-tile watchdog timeout.

Parameters:
- GAP, 2: idle cycles between a tile's TILE_DONE and the next START. 0 is legal and means back-to-back.
- TO_W, 10: width of the watchdog counter.
- TIMEOUT, 1000: WAIT cycles without TILE_DONE before ERR. Must be ≤ 2^TO_W − 1.

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RSTN  in  1  synchronous, active-high reset (1 = reset)
- JOB_VALID  in  1  job request
- JOB_READY  out  1  scheduler can accept a job
- JOB_MNT  in  12  per-tile config, forwarded to macarray MNT
- JOB_MT  in  2  row-tile count minus 1
- JOB_NT  in  2  col-tile count minus 1
- ABORT  in  1  cancel current job
- TILE_DONE  in  1  tile-complete pulse from output stage
- START  out  1  one-cycle tile start to macarray
- MNT_O  out  12  latched JOB_MNT
- TILE_ROW  out  2  current tile row index
- TILE_COL  out  2  current tile col index
- BUSY  out  1  job in progress
- JOB_DONE  out  1  one-cycle completion pulse
- ERR  out  1  sticky timeout flag

Behaviour:
- Reset, synchronous, RSTN=1 at the edge:
  - State = IDLE.
  - START=0, JOB_DONE=0, ERR=0, BUSY=0, JOB_READY=1.
  - MNT_O=0, TILE_ROW=0, TILE_COL=0; watchdog and gap counters = 0.
  - Reset overrides everything, including mid-job; no JOB_DONE is emitted.
- All outputs are registered. JOB_READY=1 only in IDLE.
- States:
  - IDLE:
    - JOB_VALID & JOB_READY at edge k: latch JOB_MNT→MNT_O and MT/NT; set TILE_ROW=TILE_COL=0; clear ERR; go to LAUNCH.
    - START=1 during cycle k+1.
  - LAUNCH:
    - START=1 for exactly this cycle; BUSY=1; clear the watchdog; go to WAIT.
  - WAIT:
    - Watchdog increments every cycle.
    - TILE_DONE=1, not last tile: advance the index, then go to GAP (GAP>0) or LAUNCH (GAP=0).
    - TILE_DONE=1, last tile (ROW=MT and COL=NT): go to DONE.
    - Watchdog reaches TIMEOUT with no TILE_DONE: ERR←1 and go to IDLE. The job is dropped and JOB_DONE is not pulsed.
    - If TILE_DONE and the timeout occur in the same cycle, TILE_DONE wins.
  - GAP:
    - Count GAP cycles, then go to LAUNCH.
    - The next START occurs exactly GAP+1 cycles after the TILE_DONE cycle.
  - DONE:
    - JOB_DONE=1 for one cycle; BUSY=1; go to IDLE. JOB_READY returns on the following cycle.
- Tile order is row-major, COL inner:
  - COL++ while COL<NT.
  - At COL=NT: COL←0 and ROW++.
  - TILE_ROW/TILE_COL are valid and stable from the LAUNCH cycle through the end of that tile's WAIT.
- TILE_DONE outside WAIT (IDLE, LAUNCH, GAP, DONE) is ignored.
- A TILE_DONE coincident with START (the LAUNCH cycle) is ignored.
- ABORT=1 in any non-IDLE state:
  - Next state IDLE; START and JOB_DONE forced 0 that edge; ERR unchanged.
  - ABORT in IDLE has no effect.
  - ABORT in the same cycle as a job accept: the abort wins and the job is not accepted.
- MNT_O holds its value after a job ends, until the next accept.
- Tile count per job = (MT+1)*(NT+1), ranging from 1 to 16.

Test Plan:
1. Reset, then a single tile: RSTN=1 for 3 cycles, then JOB_VALID with MNT=12'h444, MT=0, NT=0, accepted at edge k.
   - START high at cycle k+1 only; MNT_O=12'h444.
   - TILE_DONE at k+6 → JOB_DONE at k+7; JOB_READY=1 at k+8.
2. Grid traversal with GAP=2: MT=1, NT=2.
   - Exactly 6 START pulses, with (ROW,COL) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2).
   - Each START is 3 cycles after the preceding TILE_DONE; JOB_DONE only after the 6th TILE_DONE.
3. Timeout with TIMEOUT=20: no TILE_DONE after the first START.
   - ERR=1 and state IDLE 20 WAIT cycles later; JOB_DONE never pulses.
   - The next accepted job clears ERR.
4. Abort and stray done: ABORT asserted during the 2nd tile's WAIT of a 4-tile job.
   - Next cycle BUSY=0, JOB_READY=1, no further START, no JOB_DONE.
   - A TILE_DONE in IDLE is ignored (no state change).
5. Edge cases:
   - GAP=0: next START is the cycle immediately after TILE_DONE.
   - TILE_DONE coincident with the timeout cycle advances the tile and leaves ERR=0.
   - RSTN asserted mid-WAIT returns all outputs to reset values at the next edge.

Source files
------------

// File: rtl/mac_tile_sched.sv
// mac_tile_sched: job-level scheduler in front of the macarray top.
//
// Accepts one job per JOB_VALID/JOB_READY handshake. A job carries a 12-bit
// MNT word that is forwarded unchanged to the macarray, plus a grid size of
// (JOB_MT+1) x (JOB_NT+1) output tiles. Tiles are walked in row-major order
// with the column index as the inner loop. Each tile gets one single-cycle
// START, then the scheduler waits for TILE_DONE. Between tiles it inserts a
// drain gap of GAP idle cycles. A per-tile watchdog drops the job and raises
// a sticky ERR after TIMEOUT wait cycles without TILE_DONE.
//
// Ports:
//   CLK        clock, rising edge
//   RSTN       synchronous reset, active high (1 = reset)
//   JOB_VALID  job request           JOB_READY  scheduler idle, can accept
//   JOB_MNT    per-tile config       JOB_MT/NT  row/col tile count minus 1
//   ABORT      cancel current job    TILE_DONE  tile-complete pulse
//   START      one-cycle tile start  MNT_O      latched JOB_MNT
//   TILE_ROW   current tile row      TILE_COL   current tile column
//   BUSY       job in progress       JOB_DONE   one-cycle completion pulse
//   ERR        sticky timeout flag
//
// All outputs are registered.

module mac_tile_sched #(
    parameter int unsigned GAP     = 2,
    parameter int unsigned TO_W    = 10,
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        JOB_VALID,
    output logic        JOB_READY,
    input  logic [11:0] JOB_MNT,
    input  logic [1:0]  JOB_MT,
    input  logic [1:0]  JOB_NT,
    input  logic        ABORT,
    input  logic        TILE_DONE,
    output logic        START,
    output logic [11:0] MNT_O,
    output logic [1:0]  TILE_ROW,
    output logic [1:0]  TILE_COL,
    output logic        BUSY,
    output logic        JOB_DONE,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    localparam int unsigned GC_W = (GAP > 1) ? $clog2(GAP) : 1;
    // Terminal counts: the counters start at 0, so the last cycle is N-1.
    localparam logic [TO_W-1:0] WD_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [GC_W-1:0] GAP_LAST = GC_W'(GAP - 1);

    state_t          state;
    logic [1:0]      mt_q;
    logic [1:0]      nt_q;
    logic [TO_W-1:0] wdog;
    logic [GC_W-1:0] gap_cnt;
    logic            last_tile;

    assign last_tile = (TILE_ROW == mt_q) && (TILE_COL == nt_q);

    always_ff @(posedge CLK) begin
        if (RSTN) begin
            state     <= S_IDLE;
            START     <= 1'b0;
            JOB_DONE  <= 1'b0;
            ERR       <= 1'b0;
            BUSY      <= 1'b0;
            JOB_READY <= 1'b1;
            MNT_O     <= '0;
            TILE_ROW  <= '0;
            TILE_COL  <= '0;
            mt_q      <= '0;
            nt_q      <= '0;
            wdog      <= '0;
            gap_cnt   <= '0;
        end else begin
            // Pulse outputs default low; only the transitions below raise them.
            START    <= 1'b0;
            JOB_DONE <= 1'b0;

            if (ABORT && (state != S_IDLE)) begin
                state     <= S_IDLE;
                BUSY      <= 1'b0;
                JOB_READY <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        // An abort coincident with a request blocks the accept.
                        if (JOB_VALID && JOB_READY && !ABORT) begin
                            MNT_O     <= JOB_MNT;
                            mt_q      <= JOB_MT;
                            nt_q      <= JOB_NT;
                            TILE_ROW  <= '0;
                            TILE_COL  <= '0;
                            ERR       <= 1'b0;
                            BUSY      <= 1'b1;
                            JOB_READY <= 1'b0;
                            START     <= 1'b1;
                            state     <= S_LAUNCH;
                        end
                    end

                    S_LAUNCH: begin
                        // TILE_DONE here coincides with START and is ignored.
                        wdog  <= '0;
                        state <= S_WAIT;
                    end

                    S_WAIT: begin
                        // TILE_DONE takes priority over a same-cycle timeout.
                        if (TILE_DONE) begin
                            if (last_tile) begin
                                JOB_DONE <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                if (TILE_COL == nt_q) begin
                                    TILE_COL <= '0;
                                    TILE_ROW <= TILE_ROW + 2'd1;
                                end else begin
                                    TILE_COL <= TILE_COL + 2'd1;
                                end
                                if (GAP == 0) begin
                                    START <= 1'b1;
                                    state <= S_LAUNCH;
                                end else begin
                                    gap_cnt <= '0;
                                    state   <= S_GAP;
                                end
                            end
                        end else if (wdog == WD_LAST) begin
                            ERR       <= 1'b1;
                            BUSY      <= 1'b0;
                            JOB_READY <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            wdog <= wdog + TO_W'(1);
                        end
                    end

                    S_GAP: begin
                        // START is raised on the last gap cycle so that it is
                        // visible exactly GAP+1 cycles after TILE_DONE.
                        if (gap_cnt == GAP_LAST) begin
                            START <= 1'b1;
                            state <= S_LAUNCH;
                        end else begin
                            gap_cnt <= gap_cnt + GC_W'(1);
                        end
                    end

                    S_DONE: begin
                        BUSY      <= 1'b0;
                        JOB_READY <= 1'b1;
                        state     <= S_IDLE;
                    end

                    default: begin
                        BUSY      <= 1'b0;
                        JOB_READY <= 1'b1;
                        state     <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
